// File: rtl/vector_loader7_pkg.sv
// Shared types for the 7-word vector loader: word and vector shapes plus index width.
`include "config.svh"

package loader_pkg;
    localparam int K_OPS  = 7;
    localparam int WORD_W = `N;
    localparam int IDX_W  = $clog2(K_OPS);

    typedef logic [`N-1:0] word_t;
    typedef word_t [0:K_OPS-1] vec_t;
endpackage

// File: rtl/vector_loader7_if.sv
// Word stream in, K-word vector out, plus the framing-error pulse.
interface vector_loader7_if;
    import loader_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    word_t out_vec [0:K_OPS-1];
    logic  frame_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, frame_err
    );
endinterface

// File: rtl/config.svh
// Global word format for the loader: N-bit signed-magnitude words with F fraction bits.
`ifndef VECTOR_LOADER7_CONFIG_SVH
`define VECTOR_LOADER7_CONFIG_SVH
`define N 16
`define F 8
`endif

// File: rtl/vector_loader7.sv
// Collects serial words into 7-word vectors using two ping-pong banks, so one
// bank can be presented downstream while the other is being filled.
`include "config.svh"

module vector_loader7
    import loader_pkg::*;
#(
    parameter int N = `N,
    parameter int K = K_OPS
) (
    input  logic              clk,
    input  logic              rst_n,
    vector_loader7_if.slave   bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    logic [N-1:0]     bank_q [0:1][0:K-1];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [1:0]       fc_q, fc_d;
    logic             frame_err_q, frame_err_d;

    logic accept, take, at_last, complete, abort, wr_en;

    // Handshake outputs depend on registers only, never on in_valid/out_ready.
    assign bus.in_ready  = (fc_q != 2'd2);
    assign bus.out_valid = (fc_q != 2'd0);
    assign bus.frame_err = frame_err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign take     = bus.out_valid && bus.out_ready;
    assign at_last  = (idx_q == IDX_LAST);
    assign complete = accept && at_last;
    assign abort    = accept && !at_last && bus.in_last;
    assign wr_en    = accept && !abort;

    always_comb begin
        idx_d       = idx_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        fc_d        = fc_q;
        frame_err_d = 1'b0;

        if (accept) begin
            if (at_last) begin
                idx_d       = '0;
                wb_d        = ~wb_q;
                frame_err_d = ~bus.in_last;
            end else if (bus.in_last) begin
                idx_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (take) begin
            rb_d = ~rb_q;
        end

        // A completing frame and a take in the same cycle cancel out in fc.
        case ({complete, take})
            2'b10:   fc_d = fc_q + 2'd1;
            2'b01:   fc_d = fc_q - 2'd1;
            default: fc_d = fc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            fc_q        <= 2'd0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            fc_q        <= fc_d;
            frame_err_q <= frame_err_d;
        end
    end

    genvar gb, gi;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bank
            for (gi = 0; gi < K; gi++) begin : g_word
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        bank_q[gb][gi] <= '0;
                    end else if (wr_en && (wb_q == gb[0]) && (idx_q == IDX_W'(gi))) begin
                        bank_q[gb][gi] <= bus.in_data;
                    end
                end
            end
        end

        for (gi = 0; gi < K; gi++) begin : g_out
            assign bus.out_vec[gi] = bank_q[rb_q][gi];
        end
    endgenerate

endmodule

// File: tb/tb_vector_loader7.sv
// Directed bench for vector_loader7: framing, back-pressure, reset and a streamed run.
module tb_vector_loader7;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   err_cnt = 0;

    vector_loader7_if bus ();

    vector_loader7 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] cur_vec();
        logic [127:0] r = '0;
        for (int i = 0; i < K_OPS; i++) r |= 128'(bus.out_vec[i]) << (i * WORD_W);
        return r;
    endfunction

    function automatic logic [127:0] seq_vec(input int first);
        logic [127:0] r = '0;
        word_t w;
        for (int i = 0; i < K_OPS; i++) begin
            w = word_t'(first + i);
            r |= 128'(w) << (i * WORD_W);
        end
        return r;
    endfunction

    function automatic word_t stream_word(input int n);
        return word_t'(n * 4099 + 5);
    endfunction

    function automatic logic [127:0] stream_vec(input int v);
        logic [127:0] r = '0;
        for (int i = 0; i < K_OPS; i++) r |= 128'(stream_word(v * K_OPS + i)) << (i * WORD_W);
        return r;
    endfunction

    task automatic send(input int d, input bit last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = word_t'(d);
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_ready_timeout", 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        int e0, w, vt, cyc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_vec", cur_vec(), 128'(0));
        chk("rst_frame_err", 128'(bus.frame_err), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released");

        // Clean frame 1..7 with consumer ready
        bus.out_ready = 1'b1;
        e0 = err_cnt;
        for (int i = 1; i <= 7; i++) begin
            chk("basic_in_ready", 128'(bus.in_ready), 128'(1));
            chk("basic_no_early_valid", 128'(bus.out_valid), 128'(0));
            send(i, i == 7);
        end
        chk("basic_out_valid", 128'(bus.out_valid), 128'(1));
        chk("basic_vec", cur_vec(), seq_vec(1));
        tick();
        chk("basic_taken", 128'(bus.out_valid), 128'(0));
        chk("basic_no_err", 128'(err_cnt - e0), 128'(0));
        $display("[TB] basic frame 1..7 delivered");

        // Three frames with consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 14; i++) send(i, (i % 7) == 0);
        chk("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
        chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = word_t'(15);
        repeat (3) tick();
        chk("bp_stall_ready", 128'(bus.in_ready), 128'(0));
        chk("bp_stable_vec", cur_vec(), seq_vec(1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_vec2", cur_vec(), seq_vec(8));
        chk("bp_ready_again", 128'(bus.in_ready), 128'(1));
        for (int i = 15; i <= 21; i++) send(i, i == 21);
        chk("bp_full_again", 128'(bus.in_ready), 128'(0));
        chk("bp_vec2_hold", cur_vec(), seq_vec(8));
        bus.out_ready = 1'b1;
        tick();
        chk("bp_vec3", cur_vec(), seq_vec(15));
        tick();
        chk("bp_drained", 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b0;
        $display("[TB] back-pressure frames delivered in order");

        // Early in_last aborts the partial frame
        e0 = err_cnt;
        for (int i = 1; i <= 4; i++) send(100 + i, i == 4);
        chk("abort_err_pulse", 128'(bus.frame_err), 128'(1));
        chk("abort_no_valid", 128'(bus.out_valid), 128'(0));
        tick();
        chk("abort_err_clear", 128'(bus.frame_err), 128'(0));
        send(200, 1'b1);
        chk("abort_idx0_err", 128'(bus.frame_err), 128'(1));
        for (int i = 11; i <= 17; i++) send(i, i == 17);
        chk("abort_next_vec", cur_vec(), seq_vec(11));
        chk("abort_fc_one", 128'(bus.in_ready), 128'(1));
        chk("abort_err_count", 128'(err_cnt - e0), 128'(2));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("abort_drained", 128'(bus.out_valid), 128'(0));
        $display("[TB] aborted frames flagged");

        // Seven words with no in_last
        for (int i = 21; i <= 27; i++) send(i, 1'b0);
        chk("nolast_valid", 128'(bus.out_valid), 128'(1));
        chk("nolast_err", 128'(bus.frame_err), 128'(1));
        chk("nolast_vec", cur_vec(), seq_vec(21));
        tick();
        chk("nolast_err_clear", 128'(bus.frame_err), 128'(0));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        $display("[TB] unterminated frame delivered with error");

        // Reset with a vector pending and a partial frame
        for (int i = 31; i <= 37; i++) send(i, i == 37);
        for (int i = 41; i <= 43; i++) send(i, 1'b0);
        e0 = err_cnt;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mrst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("mrst_out_vec", cur_vec(), 128'(0));
        #1 rst_n = 1'b1;
        for (int i = 51; i <= 57; i++) send(i, i == 57);
        chk("mrst_vec", cur_vec(), seq_vec(51));
        chk("mrst_no_err", 128'(err_cnt - e0), 128'(0));
        bus.out_ready = 1'b1;
        tick();
        $display("[TB] mid-frame reset recovered");

        // 100 streamed frames with random consumer
        e0  = err_cnt;
        w   = 0;
        vt  = 0;
        cyc = 0;
        while (vt < 100 && cyc < 4000) begin
            bus.in_valid  = (w < 700);
            bus.in_data   = stream_word(w);
            bus.in_last   = ((w % 7) == 6);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                chk($sformatf("stream_vec%0d", vt), cur_vec(), stream_vec(vt));
                vt++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) w++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_count", 128'(vt), 128'(100));
        chk("stream_no_err", 128'(err_cnt - e0), 128'(0));
        $display("[TB] streamed %0d vectors in %0d cycles", vt, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_loader7.md
VECTOR_LOADER7 -- requirements
Module: vector_loader7

Interface
REQ-001 Parameter N, default `N (config.svh), word width in bits: signed-magnitude, F fraction bits.
REQ-002 Parameter K, default 7, words per output vector; only K=7 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_data holds a valid word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  N  serial operand word.
REQ-008 in_last  input  1  marks the final word of a frame; sampled only on accept.
REQ-009 out_valid  output  1  out_vec holds a complete K-word vector.
REQ-010 out_ready  input  1  consumer takes out_vec this cycle.
REQ-011 out_vec  output  [0:K-1] x N  unpacked vector; element i is the i-th accepted word of the frame; directly connectable to a 7-operand adder-tree input.
REQ-012 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 A word is accepted when in_valid and in_ready are both 1; a vector is taken when out_valid and out_ready are both 1.
REQ-014 The block holds two K-word banks (ping-pong), a write-bank bit wb, a read-bank bit rb, a word index idx (0..K-1) and a full-bank count fc (0..2).
REQ-015 in_ready = (fc != 2); out_valid = (fc != 0); out_vec = bank[rb]; these outputs are combinational from registers only, with no path from in_valid or out_ready.
REQ-016 On accept with idx < K-1 and in_last=0: bank[wb][idx] <= in_data; idx increments.
REQ-017 On accept with idx = K-1: bank[wb][K-1] <= in_data; idx <= 0; wb toggles; fc increments.
REQ-018 If in_last=0 on that K-th word, the vector still completes and frame_err pulses the next cycle.
REQ-019 On accept with in_last=1 and idx < K-1, the partial frame is discarded: idx <= 0, wb unchanged, fc unchanged, and frame_err pulses the next cycle.
REQ-020 On vector take: rb toggles; fc decrements.
REQ-021 When a frame completes and a vector is taken in the same cycle, fc is unchanged and both wb and rb toggle.
REQ-022 Latency: out_valid rises in the cycle after the K-th word is accepted.
REQ-023 Sustained throughput is 1 word/cycle while out_ready=1; no bubble at frame boundaries.
REQ-024 With fc=2, in_ready=0 and no bank content changes until a take occurs.
REQ-025 out_vec is stable while out_valid=1 and out_ready=0.
REQ-026 Data is stored bit-exact; no arithmetic, sign or fraction reinterpretation is applied.

Reset
REQ-027 When rst_n=0, asynchronously: idx=0, wb=0, rb=0, fc=0, frame_err=0, all bank words=0.
REQ-028 Resulting output values: in_ready=1, out_valid=0, out_vec all zero.
REQ-029 Reset asserted mid-frame or with a vector pending discards all data; no frame_err is raised by the reset.
REQ-030 The first accept can occur in the first rising edge after rst_n deasserts.

Structure
REQ-031 Package loader_pkg holds K_OPS=7, typedef word_t (logic [`N-1:0]) and typedef vec_t (word_t [0:K_OPS-1]); N and F remain in config.svh.
REQ-032 Single flat module with no sub-modules; the bank storage is a 2 x K array of word_t.

Verification
REQ-033 Send 7 words 1..7 with in_last on word 7 and out_ready=1 -> out_valid rises one cycle after word 7; out_vec = {1,2,3,4,5,6,7}; frame_err never asserts.
REQ-034 out_ready=0; stream 3 frames back-to-back -> in_ready drops after word 14; 3rd frame stalls; raise out_ready -> vectors arrive in order, no data loss.
REQ-035 in_last on word 4 of a frame -> frame_err pulses once; the next 7 words form the next vector; fc is unchanged by the aborted frame.
REQ-036 7 words without in_last -> vector is delivered and frame_err pulses the cycle after word 7.
REQ-037 Assert rst_n=0 mid-frame with one vector pending -> out_valid=0, in_ready=1, out_vec=0 immediately; a subsequent clean frame is delivered correctly.
REQ-038 Continuous valid/ready with random out_ready and 100 frames -> scoreboard shows in-order vectors and no frame_err.
